poly_voice_alloc: RTL and testbench

//  PS/2 keyboard note front-end for the synthesizer: decodes the raw scan-code byte stream
//  (make, F0 break, E0 extended) and allocates held notes to NUM_VOICES tone channels.

---
 rtl/synth_pkg.sv | 39 +++
 rtl/scan_to_note.sv | 47 ++++
 rtl/poly_voice_alloc.sv | 236 +++++++++++++++++++++++
 tb/tb_poly_voice_alloc.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// ----------------------------------------------------------------------------
// synth_pkg
//   Shared constants for the keyboard note front-end: the PS/2 scan-code to
//   note table, the base-frequency table, prefix bytes, octave encodings and
//   the byte-parser state encoding.
// ----------------------------------------------------------------------------
package synth_pkg;

    localparam int NOTE_CNT = 20;   // playable keys
    localparam int IDX_W    = 5;    // note index width (0..19)
    localparam int BASE_W   = 11;   // widest base frequency is 1198
    localparam int RANK_W   = 3;    // holds ranks up to 7 (NUM_VOICES <= 8)

    localparam logic [7:0] F0 = 8'hF0;  // break prefix
    localparam logic [7:0] E0 = 8'hE0;  // extended prefix

    localparam logic [1:0] OCT_UP   = 2'd1;
    localparam logic [1:0] OCT_DOWN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BRK
    } byte_state_t;

    localparam logic [7:0] SCAN_TABLE [NOTE_CNT] = '{
        8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
        8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B
    };

    localparam logic [BASE_W-1:0] BASE_TABLE [NOTE_CNT] = '{
        11'd400,  11'd423,  11'd448,  11'd475,  11'd503,
        11'd533,  11'd565,  11'd599,  11'd634,  11'd672,
        11'd712,  11'd755,  11'd800,  11'd847,  11'd897,
        11'd951,  11'd1007, 11'd1067, 11'd1131, 11'd1198
    };

endpackage

// File: rtl/scan_to_note.sv
// ----------------------------------------------------------------------------
// scan_to_note
//   Purely combinational note lookup, shared with the VGA keyboard overlay.
//   Decodes one raw scan code into {hit, idx} and translates LOOKUPS note
//   indices into base frequencies in parallel.
// Ports
//   scan_code  in   8                 raw PS/2 byte
//   hit        out  1                 scan_code is one of the 20 note keys
//   idx        out  IDX_W             note index of scan_code (0 when !hit)
//   note_idx   in   LOOKUPS*IDX_W     packed note indices to translate
//   base_freq  out  LOOKUPS*BASE_W    packed base frequencies (0 if index >= 20)
// ----------------------------------------------------------------------------
module scan_to_note
    import synth_pkg::*;
#(
    parameter int LOOKUPS = 1
) (
    input  logic [7:0]                scan_code,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx,
    input  logic [LOOKUPS*IDX_W-1:0]  note_idx,
    output logic [LOOKUPS*BASE_W-1:0] base_freq
);

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NOTE_CNT; i++) begin
            if (scan_code == SCAN_TABLE[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        base_freq = '0;
        for (int l = 0; l < LOOKUPS; l++) begin
            if (int'(note_idx[l*IDX_W +: IDX_W]) < NOTE_CNT) begin
                base_freq[l*BASE_W +: BASE_W] = BASE_TABLE[note_idx[l*IDX_W +: IDX_W]];
            end
        end
    end

endmodule

// File: rtl/poly_voice_alloc.sv
// ----------------------------------------------------------------------------
// poly_voice_alloc
//   PS/2 keyboard note front-end. Parses the scan-code byte stream (make, F0
//   break, E0 extended), allocates held notes to NUM_VOICES tone channels with
//   oldest-note stealing, and drives registered frequency words, gates and a
//   held-key bitmap.
// Ports
//   CLK_50      in   1                  system clock, rising edge
//   RST_N       in   1                  asynchronous active-low reset
//   scan_valid  in   1                  scan_code holds a new byte this cycle
//   scan_code   in   8                  raw PS/2 byte
//   octave_sel  in   2                  0/3 normal, 1 up one octave, 2 down one
//   all_off     in   1                  synchronous release of every voice
//   freq_out    out  NUM_VOICES*FREQ_W  voice v at [v*FREQ_W +: FREQ_W]
//   gate        out  NUM_VOICES         1 = voice sounding
//   key_held    out  NOTE_CNT           bit k = note k is assigned to a voice
// ----------------------------------------------------------------------------
module poly_voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int FREQ_W     = 16,
    parameter int IDLE_FREQ  = 1
) (
    input  logic                         CLK_50,
    input  logic                         RST_N,
    input  logic                         scan_valid,
    input  logic [7:0]                   scan_code,
    input  logic [1:0]                   octave_sel,
    input  logic                         all_off,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_out,
    output logic [NUM_VOICES-1:0]        gate,
    output logic [NOTE_CNT-1:0]          key_held
);

    localparam int                VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [RANK_W-1:0] RANK_MAX  = RANK_W'(NUM_VOICES - 1);
    localparam logic [FREQ_W-1:0] IDLE_WORD = FREQ_W'(IDLE_FREQ);

    // ------------------------------------------------------------------
    // Note lookup: one decoder for the incoming byte, one frequency
    // translation per voice.
    // ------------------------------------------------------------------
    logic                           code_hit;
    logic [IDX_W-1:0]               code_idx;
    logic [NUM_VOICES*IDX_W-1:0]    lookup_idx;
    logic [NUM_VOICES*BASE_W-1:0]   lookup_base;

    // Voice table
    logic [NUM_VOICES-1:0] active_q;
    logic [IDX_W-1:0]      idx_q  [NUM_VOICES];
    logic [RANK_W-1:0]     rank_q [NUM_VOICES];

    scan_to_note #(
        .LOOKUPS   (NUM_VOICES)
    ) u_scan_to_note (
        .scan_code (scan_code),
        .hit       (code_hit),
        .idx       (code_idx),
        .note_idx  (lookup_idx),
        .base_freq (lookup_base)
    );

    always_comb begin
        lookup_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            lookup_idx[v*IDX_W +: IDX_W] = idx_q[v];
        end
    end

    // ------------------------------------------------------------------
    // Byte parser
    // ------------------------------------------------------------------
    byte_state_t state_q, state_d;
    logic        make_ev, rel_ev;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        make_ev = 1'b0;
        rel_ev  = 1'b0;
        if (all_off) begin
            // Panic discards any byte arriving in the same cycle.
            state_d = ST_IDLE;
        end else if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == F0) begin
                        state_d = ST_BREAK;
                    end else if (scan_code == E0) begin
                        state_d = ST_EXT;
                    end else begin
                        make_ev = code_hit;
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    rel_ev  = code_hit;
                end
                ST_EXT: begin
                    // Extended keys are never notes; only track the break
                    // prefix so the trailing byte is swallowed.
                    state_d = (scan_code == F0) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Allocation: duplicate detection, lowest free voice, steal candidate
    // (highest rank, ties resolved toward the lowest index by strict >).
    // ------------------------------------------------------------------
    logic               already_held;
    logic               free_found;
    logic [VOICE_W-1:0] free_v;
    logic [VOICE_W-1:0] steal_v;
    logic [VOICE_W-1:0] chosen_v;
    logic [RANK_W-1:0]  best_rank;

    always_comb begin
        already_held = 1'b0;
        free_found   = 1'b0;
        free_v       = '0;
        steal_v      = '0;
        best_rank    = rank_q[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && (idx_q[v] == code_idx)) begin
                already_held = 1'b1;
            end
            if (!active_q[v] && !free_found) begin
                free_found = 1'b1;
                free_v     = VOICE_W'(v);
            end
            if (rank_q[v] > best_rank) begin
                best_rank = rank_q[v];
                steal_v   = VOICE_W'(v);
            end
        end
        chosen_v = free_found ? free_v : steal_v;
    end

    // NOTE: the voice table is a handful of flops, not a RAM, so it is reset
    // in full; a stale idx or rank must never leak into the steal decision.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            active_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                idx_q[v]  <= '0;
                rank_q[v] <= '0;
            end
        end else if (all_off) begin
            active_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                rank_q[v] <= '0;
            end
        end else if (make_ev && !already_held) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VOICE_W'(v) == chosen_v) begin
                    active_q[v] <= 1'b1;
                    idx_q[v]    <= code_idx;
                    rank_q[v]   <= '0;
                end else if (active_q[v] && (rank_q[v] != RANK_MAX)) begin
                    rank_q[v] <= rank_q[v] + RANK_W'(1);
                end
            end
        end else if (rel_ev) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && (idx_q[v] == code_idx)) begin
                    active_q[v] <= 1'b0;
                    rank_q[v]   <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: octave shift is applied here so it affects every
    // sounding voice one cycle after octave_sel changes.
    // ------------------------------------------------------------------
    function automatic logic [FREQ_W-1:0] apply_octave(input logic [BASE_W-1:0] base,
                                                       input logic [1:0]        oct);
        case (oct)
            OCT_UP:   return FREQ_W'({base, 1'b0});
            OCT_DOWN: return FREQ_W'(base >> 1);
            default:  return FREQ_W'(base);
        endcase
    endfunction

    logic [NUM_VOICES*FREQ_W-1:0] freq_d;
    logic [NOTE_CNT-1:0]          key_d;

    always_comb begin
        freq_d = '0;
        key_d  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            freq_d[v*FREQ_W +: FREQ_W] = active_q[v]
                ? apply_octave(lookup_base[v*BASE_W +: BASE_W], octave_sel)
                : IDLE_WORD;
        end
        for (int k = 0; k < NOTE_CNT; k++) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && (idx_q[v] == IDX_W'(k))) begin
                    key_d[k] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            freq_out <= {NUM_VOICES{IDLE_WORD}};
            gate     <= '0;
            key_held <= '0;
        end else begin
            freq_out <= freq_d;
            gate     <= active_q;
            key_held <= key_d;
        end
    end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// ----------------------------------------------------------------------------
// tb_poly_voice_alloc
//   Self-checking bench for poly_voice_alloc (3 voices, 16-bit words). A
//   behavioural model tracks the prefix bytes seen, which key each voice holds
//   and each voice's steal rank; expected outputs are derived from it.
// ----------------------------------------------------------------------------
module tb_poly_voice_alloc;

    localparam int NV = 3;
    localparam int FW = 16;

    logic             CLK_50     = 1'b0;
    logic             RST_N      = 1'b0;
    logic             scan_valid = 1'b0;
    logic [7:0]       scan_code  = 8'h00;
    logic [1:0]       octave_sel = 2'd0;
    logic             all_off    = 1'b0;
    logic [NV*FW-1:0] freq_out;
    logic [NV-1:0]    gate;
    logic [19:0]      key_held;

    int checks   = 0;
    int failures = 0;

    always #10 CLK_50 = ~CLK_50;

    poly_voice_alloc #(
        .NUM_VOICES (NV),
        .FREQ_W     (FW),
        .IDLE_FREQ  (1)
    ) dut (
        .CLK_50     (CLK_50),
        .RST_N      (RST_N),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .octave_sel (octave_sel),
        .all_off    (all_off),
        .freq_out   (freq_out),
        .gate       (gate),
        .key_held   (key_held)
    );

    // ---------------------------------------------------------------- model
    int scan_list [20] = '{'h15, 'h1C, 'h1D, 'h1B, 'h24, 'h23, 'h2B, 'h2C, 'h34, 'h35,
                           'h33, 'h3B, 'h43, 'h42, 'h44, 'h4B, 'h4D, 'h4C, 'h52, 'h5B};
    int base_list [20] = '{400, 423, 448, 475, 503, 533, 565, 599, 634, 672,
                           712, 755, 800, 847, 897, 951, 1007, 1067, 1131, 1198};

    bit m_act  [NV];
    int m_key  [NV];
    int m_rank [NV];
    bit m_after_e0;
    bit m_after_f0;

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 20; i++) if (scan_list[i] == int'(b)) return i;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int v = 0; v < NV; v++) begin
            m_act[v]  = 1'b0;
            m_key[v]  = 0;
            m_rank[v] = 0;
        end
        m_after_e0 = 1'b0;
        m_after_f0 = 1'b0;
    endfunction

    function automatic void model_make(input int k);
        int pick;
        for (int v = 0; v < NV; v++) if (m_act[v] && m_key[v] == k) return;
        pick = -1;
        for (int v = 0; v < NV; v++) if (!m_act[v]) begin pick = v; break; end
        if (pick < 0) begin
            pick = 0;
            for (int v = 1; v < NV; v++) if (m_rank[v] > m_rank[pick]) pick = v;
        end
        for (int v = 0; v < NV; v++) begin
            if (v == pick) begin
                m_act[v]  = 1'b1;
                m_key[v]  = k;
                m_rank[v] = 0;
            end else if (m_act[v]) begin
                m_rank[v] = (m_rank[v] + 1 > NV - 1) ? NV - 1 : m_rank[v] + 1;
            end
        end
    endfunction

    function automatic void model_release(input int k);
        for (int v = 0; v < NV; v++) if (m_act[v] && m_key[v] == k) m_act[v] = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int k;
        k = note_of(b);
        if (m_after_e0) begin
            if (m_after_f0) begin
                m_after_e0 = 1'b0;
                m_after_f0 = 1'b0;
            end else if (b == 8'hF0) begin
                m_after_f0 = 1'b1;
            end else begin
                m_after_e0 = 1'b0;
            end
        end else if (m_after_f0) begin
            if (k >= 0) model_release(k);
            m_after_f0 = 1'b0;
        end else if (b == 8'hF0) begin
            m_after_f0 = 1'b1;
        end else if (b == 8'hE0) begin
            m_after_e0 = 1'b1;
        end else if (k >= 0) begin
            model_make(k);
        end
    endfunction

    function automatic logic [NV*FW-1:0] exp_freq();
        logic [NV*FW-1:0] r;
        int f;
        r = '0;
        for (int v = 0; v < NV; v++) begin
            if (m_act[v]) begin
                f = base_list[m_key[v]];
                if (octave_sel == 2'd1) f = f * 2;
                else if (octave_sel == 2'd2) f = f / 2;
                r[v*FW +: FW] = 16'(f);
            end else begin
                r[v*FW +: FW] = 16'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_act[v];
        return r;
    endfunction

    function automatic logic [19:0] exp_keys();
        logic [19:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) if (m_act[v]) r[m_key[v]] = 1'b1;
        return r;
    endfunction

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
        if (all_off) model_clear();
        else model_byte(b);
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        RST_N = 1'b0;
        model_clear();
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        checks++;
        if (gate !== 3'b000) begin
            failures++;
            $display("FAIL reset_gate actual=%b required=000", gate);
        end
        checks++;
        if (freq_out !== {3{16'd1}}) begin
            failures++;
            $display("FAIL reset_freq actual=%h required=%h", freq_out, {3{16'd1}});
        end
        checks++;
        if (key_held !== 20'h0) begin
            failures++;
            $display("FAIL reset_keys actual=%h required=00000", key_held);
        end
    endtask

    task automatic test_single_note();
        send_byte(8'h1C);
        checks++;
        if (gate !== 3'b000) begin
            failures++;
            $display("FAIL single_latency actual=%b required=000", gate);
        end
        tick();
        checks++;
        if (gate !== 3'b001 || freq_out[15:0] !== 16'd423) begin
            failures++;
            $display("FAIL single_make gate=%b freq0=%0d required gate=001 freq0=423",
                     gate, freq_out[15:0]);
        end
        checks++;
        if (key_held !== 20'h00002) begin
            failures++;
            $display("FAIL single_keys actual=%h required=00002", key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick();
        checks++;
        if (gate !== 3'b000 || freq_out[15:0] !== 16'd1) begin
            failures++;
            $display("FAIL single_release gate=%b freq0=%0d required gate=000 freq0=1",
                     gate, freq_out[15:0]);
        end
    endtask

    task automatic test_steal();
        send_byte(8'h2B);
        send_byte(8'h34);
        send_byte(8'h33);
        tick();
        checks++;
        if (freq_out !== {16'd712, 16'd634, 16'd565} || gate !== 3'b111) begin
            failures++;
            $display("FAIL steal_fill freq=%h gate=%b required freq=%h gate=111",
                     freq_out, gate, {16'd712, 16'd634, 16'd565});
        end
        send_byte(8'h3B);
        tick();
        checks++;
        if (freq_out !== {16'd712, 16'd634, 16'd755}) begin
            failures++;
            $display("FAIL steal_oldest freq=%h required=%h", freq_out, {16'd712, 16'd634, 16'd755});
        end
        // Ranks are now v1=2, v2=1, so the next steal must take voice 1.
        send_byte(8'h42);
        tick();
        checks++;
        if (freq_out !== {16'd712, 16'd847, 16'd755} || key_held !== exp_keys()) begin
            failures++;
            $display("FAIL steal_rank freq=%h keys=%h required freq=%h keys=%h",
                     freq_out, key_held, {16'd712, 16'd847, 16'd755}, exp_keys());
        end
        send_byte(8'hF0); send_byte(8'h3B);
        send_byte(8'hF0); send_byte(8'h42);
        send_byte(8'hF0); send_byte(8'h33);
        tick();
        checks++;
        if (gate !== 3'b000 || key_held !== 20'h0) begin
            failures++;
            $display("FAIL steal_clear gate=%b keys=%h required gate=000 keys=00000", gate, key_held);
        end
    endtask

    task automatic test_typematic();
        send_byte(8'h2B);
        send_byte(8'h2B);
        send_byte(8'h2B);
        tick();
        checks++;
        if (gate !== 3'b001 || key_held !== 20'h00040 || freq_out[15:0] !== 16'd565) begin
            failures++;
            $display("FAIL typematic gate=%b keys=%h freq0=%0d required gate=001 keys=00040 freq0=565",
                     gate, key_held, freq_out[15:0]);
        end
        send_byte(8'hF0);
        send_byte(8'h2B);
        tick();
        checks++;
        if (gate !== 3'b000 || key_held !== 20'h0) begin
            failures++;
            $display("FAIL typematic_release gate=%b keys=%h required gate=000 keys=00000", gate, key_held);
        end
    endtask

    task automatic test_octave();
        send_byte(8'h4C);
        tick();
        octave_sel = 2'd1;
        tick();
        checks++;
        if (freq_out[15:0] !== 16'd2134) begin
            failures++;
            $display("FAIL octave_up actual=%0d required=2134", freq_out[15:0]);
        end
        octave_sel = 2'd2;
        tick();
        checks++;
        if (freq_out[15:0] !== 16'd533) begin
            failures++;
            $display("FAIL octave_down actual=%0d required=533", freq_out[15:0]);
        end
        octave_sel = 2'd3;
        tick();
        checks++;
        if (freq_out[15:0] !== 16'd1067 || freq_out[47:16] !== {2{16'd1}}) begin
            failures++;
            $display("FAIL octave_normal actual=%h required=000100011067-equivalent %h",
                     freq_out, {16'd1, 16'd1, 16'd1067});
        end
        octave_sel = 2'd0;
        send_byte(8'hF0);
        send_byte(8'h4C);
        tick();
    endtask

    task automatic test_ignored();
        send_byte(8'h1C);
        tick();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h1A);
        send_byte(8'hF0); send_byte(8'h5B);
        tick();
        checks++;
        if (gate !== 3'b001 || freq_out !== {16'd1, 16'd1, 16'd423} || key_held !== 20'h00002) begin
            failures++;
            $display("FAIL ignored_bytes gate=%b freq=%h keys=%h required gate=001 freq=%h keys=00002",
                     gate, freq_out, key_held, {16'd1, 16'd1, 16'd423});
        end
        // A note key following E0 or E0 F0 must not act as make or release.
        send_byte(8'hE0); send_byte(8'h2B);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
        tick();
        checks++;
        if (gate !== 3'b001 || key_held !== 20'h00002) begin
            failures++;
            $display("FAIL ignored_extended gate=%b keys=%h required gate=001 keys=00002", gate, key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick();
    endtask

    task automatic test_all_off();
        send_byte(8'h15);
        send_byte(8'h1D);
        tick();
        all_off = 1'b1;
        send_byte(8'h15);
        all_off = 1'b0;
        tick();
        checks++;
        if (gate !== 3'b000 || freq_out !== {3{16'd1}} || key_held !== 20'h0) begin
            failures++;
            $display("FAIL all_off_clear gate=%b freq=%h keys=%h required gate=000 freq=%h keys=00000",
                     gate, freq_out, key_held, {3{16'd1}});
        end
        // all_off also abandons a pending break prefix.
        send_byte(8'hF0);
        all_off = 1'b1;
        tick();
        all_off = 1'b0;
        model_clear();
        send_byte(8'h1D);
        tick();
        checks++;
        if (gate !== 3'b001 || freq_out[15:0] !== 16'd448) begin
            failures++;
            $display("FAIL all_off_prefix gate=%b freq0=%0d required gate=001 freq0=448",
                     gate, freq_out[15:0]);
        end
        send_byte(8'hF0);
        send_byte(8'h1D);
        tick();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h1C);
        tick();
        send_byte(8'hF0);
        RST_N = 1'b0;
        #1;
        checks++;
        if (gate !== 3'b000 || key_held !== 20'h0) begin
            failures++;
            $display("FAIL reset_async gate=%b keys=%h required gate=000 keys=00000", gate, key_held);
        end
        #3;
        RST_N = 1'b1;
        model_clear();
        tick();
        send_byte(8'h1C);
        tick();
        checks++;
        if (gate !== 3'b001 || key_held !== 20'h00002) begin
            failures++;
            $display("FAIL reset_mid_make gate=%b keys=%h required gate=001 keys=00002", gate, key_held);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        tick();
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                b = 8'(scan_list[(r < 30) ? $urandom_range(0, 5) : $urandom_range(0, 19)]);
                send_byte(b);
            end else if (r < 75) begin
                send_byte(8'hF0);
            end else if (r < 80) begin
                send_byte(8'hE0);
            end else if (r < 88) begin
                send_byte(8'($urandom_range(0, 255)));
            end else if (r < 93) begin
                octave_sel = 2'($urandom_range(0, 3));
                tick();
            end else if (r < 96) begin
                all_off    = 1'b1;
                scan_valid = 1'($urandom_range(0, 1));
                scan_code  = 8'(scan_list[$urandom_range(0, 19)]);
                tick();
                all_off    = 1'b0;
                scan_valid = 1'b0;
                model_clear();
            end else begin
                tick();
            end
            tick();
            checks++;
            if ({freq_out, gate, key_held} !== {exp_freq(), exp_gate(), exp_keys()}) begin
                failures++;
                $display("FAIL random_step%0d freq=%h gate=%b keys=%h required freq=%h gate=%b keys=%h",
                         n, freq_out, gate, key_held, exp_freq(), exp_gate(), exp_keys());
            end
            checks++;
            if ($countones(key_held) != $countones(gate)) begin
                failures++;
                $display("FAIL random_popcount%0d keys=%0d gates=%0d required equal",
                         n, $countones(key_held), $countones(gate));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_note();
        test_steal();
        test_typematic();
        test_octave();
        test_ignored();
        test_all_off();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
